simd_pipe_adder: RTL and testbench
==================================

SIMD_PIPE_ADDER -- requirements
Module: simd_pipe_adder

Interface
REQ-001 Parameter WIDTH, default 64: datapath width; SHALL be a multiple of 64.
REQ-002 Parameter CHUNK, default 16: bits added per pipeline stage; SHALL be 8 or 16.
REQ-003 Port clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: reset, synchronous and active-high.
REQ-005 Port A, B  input  WIDTH: operands; bit 0 is the least-significant bit of lane 0, and carry propagates toward higher indices.
REQ-006 Port Ci  input  1: carry-in, applied at the LSB of every lane.
REQ-007 Port mode  input  2: lane width; 0 = 16-bit lanes, 1 = 32-bit lanes, 2 = 64-bit lanes, 3 = reserved (treated as 2).
REQ-008 Port sub  input  1: 1 selects S = A - B per lane.
REQ-009 Port in_valid  input  1; in_ready  output  1: input handshake.
REQ-010 Port S  output  WIDTH: sum or difference.
REQ-011 Port Co  output  WIDTH/16: carry-out of each 16-bit slot; only the slot holding a lane's MSB carries that lane's carry, all other bits are 0.
REQ-012 Port out_valid  output  1; out_ready  input  1: output handshake.

Function
REQ-013 A transfer SHALL be accepted when in_valid and in_ready are both 1; A, B, Ci, mode and sub SHALL be captured with it.
REQ-014 The pipeline SHALL have STAGES = WIDTH/CHUNK registered stages, and stage k SHALL add chunk k together with the registered carry from stage k-1.
REQ-015 Latency SHALL be STAGES cycles from acceptance to out_valid when there is no stall, and throughput SHALL be one transfer per cycle.
REQ-016 The inter-chunk carry SHALL be forced to the lane carry-in at every lane boundary set by the captured mode (boundaries every 16, 32 or 64 bits).
REQ-017 When sub = 1, B SHALL be bitwise inverted and the lane carry-in SHALL be 1, with Ci ignored; Co then carries the no-borrow flag.
REQ-018 Each transfer SHALL keep its captured mode and sub through every stage, so back-to-back transfers with different modes never mix.
REQ-019 All arithmetic SHALL be modulo the lane width, with no saturation.
REQ-020 Stall: when out_valid = 1 and out_ready = 0, all stages SHALL hold, in_ready SHALL be 0, and S, Co and out_valid SHALL stay stable.
REQ-021 in_ready SHALL equal (not out_valid) or out_ready, so a full pipeline drains and refills on the same cycle.
REQ-022 Pipeline bubbles SHALL propagate as invalid stages, and out_valid SHALL be 1 only for accepted transfers, in order.
REQ-023 The datapath SHALL contain no state machine beyond the per-stage valid bits.

Reset
REQ-024 While rst = 1, every stage valid bit SHALL clear and out_valid SHALL be 0.
REQ-025 While rst = 1, S and Co SHALL be 0 and in_ready SHALL be 0.
REQ-026 A reset asserted mid-operation SHALL discard all in-flight transfers, and no discarded result SHALL ever appear.
REQ-027 in_ready SHALL be 1 on the first cycle after rst deasserts.

Structure
REQ-028 A shared package SHALL hold the mode encodings (MODE_16, MODE_32, MODE_64) and the LANE_MIN = 16 constant.
REQ-029 One sub-module, simd_chunk_stage, SHALL implement one CHUNK-wide add, the boundary carry mux and the stage register with hold, instantiated STAGES times in a generate loop.

Verification (WIDTH = 64, CHUNK = 16, latency 4)
REQ-030 Case 1: mode = 2, A = 0xFFFF_FFFF_FFFF_FFFF, B = 1, Ci = 0 -> after 4 cycles S = 0 and Co = 4'b1000.
REQ-031 Case 2: mode = 0, A = 0xFFFF_0001_FFFF_0001, B = 0x0001_0001_0001_0001, Ci = 0 -> S = 0x0000_0002_0000_0002 and Co = 4'b1010 (lanes 1 and 3 carry, no cross-lane carry).
REQ-032 Case 3: mode = 1, sub = 1, A = 0x0000_0005_0000_0003, B = 0x0000_0003_0000_0005 -> S = 0x0000_0002_FFFF_FFFE and Co = 4'b1000.
REQ-033 Case 4: back-to-back transfers with mode 0, 1, 2, each A = B = 0x8000_8000_8000_8000 -> outputs 0x0000_0000_0000_0000 (Co = 4'b1111), 0x0001_0000_0001_0000 (Co = 4'b1010), 0x0001_0001_0001_0000 (Co = 4'b1000) on consecutive cycles.
REQ-034 Case 5: stream of 8 transfers with out_ready low for 3 cycles mid-stream -> outputs held stable, no loss or duplication, original order kept.
REQ-035 Case 6: rst pulsed for 1 cycle with 3 transfers in flight -> out_valid stays 0 and none of the 3 results is ever emitted.

Source files
------------

// File: rtl/simd_pipe_adder_pkg.sv
// Shared constants for the SIMD pipelined adder: lane-width encodings and the
// lane-boundary helper used by every chunk stage.
package simd_pipe_adder_pkg;

  typedef enum logic [1:0] {
    MODE_16   = 2'd0,
    MODE_32   = 2'd1,
    MODE_64   = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  localparam int LANE_MIN = 16;

  // True when bit position pos starts a new lane (or is the datapath end) for the
  // given mode; the reserved encoding behaves like 64-bit lanes.
  function automatic logic is_lane_edge(input int pos, input logic [1:0] mode);
    logic at_edge;
    case (mode)
      MODE_16: at_edge = (pos % LANE_MIN) == 0;
      MODE_32: at_edge = (pos % (2 * LANE_MIN)) == 0;
      default: at_edge = (pos % (4 * LANE_MIN)) == 0;
    endcase
    return at_edge;
  endfunction

endpackage

// File: rtl/simd_pipe_adder_if.sv
// Handshake and operand bus between the SIMD adder and its producer/consumer.
interface simd_pipe_adder_if #(
  parameter int WIDTH = 64
) ();
  logic [WIDTH-1:0]    A;
  logic [WIDTH-1:0]    B;
  logic                Ci;
  logic [1:0]          mode;
  logic                sub;
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    S;
  logic [WIDTH/16-1:0] Co;
  logic                out_valid;
  logic                out_ready;

  modport slave (
    input  A, B, Ci, mode, sub, in_valid, out_ready,
    output in_ready, S, Co, out_valid
  );

  modport master (
    output A, B, Ci, mode, sub, in_valid, out_ready,
    input  in_ready, S, Co, out_valid
  );
endinterface

// File: rtl/simd_chunk_stage.sv
// One pipeline stage: adds chunk IDX of the travelling operands with the carry
// from the previous stage, restarting the carry at lane boundaries.
module simd_chunk_stage
  import simd_pipe_adder_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16,
  parameter int IDX   = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                prev_valid,
  input  logic [1:0]          prev_mode,
  input  logic                prev_sub,
  input  logic                prev_ci,
  input  logic                prev_carry,
  input  logic [WIDTH-1:0]    prev_a,
  input  logic [WIDTH-1:0]    prev_b,
  input  logic [WIDTH-1:0]    prev_s,
  input  logic [WIDTH/16-1:0] prev_co,
  output logic                valid,
  output logic [1:0]          mode,
  output logic                sub,
  output logic                ci,
  output logic                carry,
  output logic [WIDTH-1:0]    a,
  output logic [WIDTH-1:0]    b,
  output logic [WIDTH-1:0]    s,
  output logic [WIDTH/16-1:0] co
);
  localparam int LO   = IDX * CHUNK;
  localparam int HI   = LO + CHUNK;
  localparam int SLOT = (HI >= LANE_MIN) ? (HI / LANE_MIN) - 1 : 0;

  logic                cin;
  logic [CHUNK:0]      sum;
  logic [WIDTH-1:0]    s_next;
  logic [WIDTH/16-1:0] co_next;

  // Chunk add; the lane MSB chunk also publishes the lane carry into its Co slot.
  always_comb begin
    cin = is_lane_edge(LO, prev_mode) ? (prev_sub ? 1'b1 : prev_ci) : prev_carry;
    sum = {1'b0, prev_a[LO +: CHUNK]}
        + {1'b0, prev_b[LO +: CHUNK] ^ {CHUNK{prev_sub}}}
        + {{CHUNK{1'b0}}, cin};
    s_next = prev_s;
    s_next[LO +: CHUNK] = sum[CHUNK-1:0];
    co_next = prev_co;
    if (is_lane_edge(HI, prev_mode)) begin
      co_next[SLOT] = sum[CHUNK];
    end else begin
      co_next[SLOT] = prev_co[SLOT];
    end
  end

  // Stage register; holds everything while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      mode  <= 2'd0;
      sub   <= 1'b0;
      ci    <= 1'b0;
      carry <= 1'b0;
      a     <= '0;
      b     <= '0;
      s     <= '0;
      co    <= '0;
    end else if (en) begin
      valid <= prev_valid;
      mode  <= prev_mode;
      sub   <= prev_sub;
      ci    <= prev_ci;
      carry <= sum[CHUNK];
      a     <= prev_a;
      b     <= prev_b;
      s     <= s_next;
      co    <= co_next;
    end
  end

endmodule

// File: rtl/simd_pipe_adder.sv
// SIMD add/subtract with 16/32/64-bit lanes, computed one CHUNK per stage so
// each transfer carries its own mode and sub down the pipe.
module simd_pipe_adder
  import simd_pipe_adder_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input logic               clk,
  input logic               rst,
  simd_pipe_adder_if.slave  bus
);
  localparam int STAGES = WIDTH / CHUNK;

  // Index 0 is the input bus, index k+1 is the register of stage k.
  logic                val   [STAGES+1];
  logic [1:0]          mode  [STAGES+1];
  logic                sub   [STAGES+1];
  logic                ci    [STAGES+1];
  logic                carry [STAGES+1];
  logic [WIDTH-1:0]    a     [STAGES+1];
  logic [WIDTH-1:0]    b     [STAGES+1];
  logic [WIDTH-1:0]    s     [STAGES+1];
  logic [WIDTH/16-1:0] co    [STAGES+1];
  logic                en;
  logic                unused_tail;

  assign val[0]   = bus.in_valid;
  assign mode[0]  = bus.mode;
  assign sub[0]   = bus.sub;
  assign ci[0]    = bus.Ci;
  assign carry[0] = 1'b0;
  assign a[0]     = bus.A;
  assign b[0]     = bus.B;
  assign s[0]     = '0;
  assign co[0]    = '0;

  // A single advance enable keeps every stage in lockstep, bubbles included.
  assign en            = !val[STAGES] || bus.out_ready;
  assign bus.in_ready  = !rst && en;
  assign bus.out_valid = val[STAGES];
  assign bus.S         = s[STAGES];
  assign bus.Co        = co[STAGES];
  assign unused_tail   = ^{a[STAGES], b[STAGES], mode[STAGES], sub[STAGES],
                           ci[STAGES], carry[STAGES]};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    simd_chunk_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .IDX   (k)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .prev_valid (val[k]),
      .prev_mode  (mode[k]),
      .prev_sub   (sub[k]),
      .prev_ci    (ci[k]),
      .prev_carry (carry[k]),
      .prev_a     (a[k]),
      .prev_b     (b[k]),
      .prev_s     (s[k]),
      .prev_co    (co[k]),
      .valid      (val[k+1]),
      .mode       (mode[k+1]),
      .sub        (sub[k+1]),
      .ci         (ci[k+1]),
      .carry      (carry[k+1]),
      .a          (a[k+1]),
      .b          (b[k+1]),
      .s          (s[k+1]),
      .co         (co[k+1])
    );
  end

endmodule

// File: tb/tb_simd_pipe_adder.sv
// Randomized and directed bench for simd_pipe_adder (WIDTH 64, CHUNK 16) with a
// lane-arithmetic reference model and an in-order scoreboard.
module tb_simd_pipe_adder;
  import simd_pipe_adder_pkg::*;

  typedef struct packed {
    logic [63:0] s;
    logic [3:0]  co;
  } res_t;

  typedef struct {
    res_t r;
    int   cyc;
  } ent_t;

  logic clk = 1'b0;
  logic rst;

  simd_pipe_adder_if #(.WIDTH(64)) bus ();

  simd_pipe_adder #(.WIDTH(64), .CHUNK(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  ent_t        q[$];
  logic        o_valid;
  logic        o_in_ready;
  logic        fire_out;
  logic [63:0] o_s;
  logic [3:0]  o_co;
  int          o_cyc;

  function automatic res_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic ci, input logic [1:0] m, input logic sb);
    res_t        r;
    int          lw;
    logic [64:0] mask;
    logic [64:0] la;
    logic [64:0] lb;
    logic [64:0] sum;
    lw   = (m == 2'd0) ? 16 : (m == 2'd1) ? 32 : 64;
    mask = (65'd1 << lw) - 65'd1;
    r    = '0;
    for (int i = 0; i < 64 / lw; i++) begin
      la = ({1'b0, a} >> (i * lw)) & mask;
      lb = ({1'b0, b} >> (i * lw)) & mask;
      if (sb) lb = ~lb & mask;
      sum = la + lb + 65'(sb ? 1'b1 : ci);
      r.s = r.s | 64'((sum & mask) << (i * lw));
      r.co[(i + 1) * lw / 16 - 1] = sum[lw];
    end
    return r;
  endfunction

  // Drive one cycle, sample outputs before the edge, record any accepted transfer.
  task automatic step(input logic r, input logic v, input logic [63:0] a,
                      input logic [63:0] b, input logic ci, input logic [1:0] m,
                      input logic sb, input logic ordy);
    ent_t e;
    @(negedge clk);
    rst = r;
    bus.in_valid = v;
    bus.A = a;
    bus.B = b;
    bus.Ci = ci;
    bus.mode = m;
    bus.sub = sb;
    bus.out_ready = ordy;
    #1;
    o_valid    = bus.out_valid;
    o_s        = bus.S;
    o_co       = bus.Co;
    o_in_ready = bus.in_ready;
    o_cyc      = cyc;
    fire_out   = o_valid && ordy;
    if (v && o_in_ready) begin
      e.r   = model(a, b, ci, m, sb);
      e.cyc = cyc;
      q.push_back(e);
    end
    cyc++;
    @(posedge clk);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 2'd0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 2'd0, 1'b0, 1'b1);
    vectors += 4;
    if (o_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", o_valid); end
    if (o_s !== 64'd0) begin miscompares++; $display("FAIL reset_S: got %h want 0", o_s); end
    if (o_co !== 4'd0) begin miscompares++; $display("FAIL reset_Co: got %b want 0000", o_co); end
    if (o_in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b want 0", o_in_ready); end
    step(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 2'd0, 1'b0, 1'b1);
    vectors++;
    if (o_in_ready !== 1'b1) begin miscompares++; $display("FAIL first_ready: got %b want 1", o_in_ready); end
  endtask

  task automatic test_directed();
    logic [63:0] da [6];
    logic [63:0] db [6];
    logic [1:0]  dm [6];
    logic        ds [6];
    logic        dc [6];
    logic [63:0] es [6];
    logic [3:0]  ec [6];
    int          sent = 0;
    int          got = 0;
    ent_t        e;
    da[0] = 64'hFFFF_FFFF_FFFF_FFFF; db[0] = 64'h1;                   dm[0] = 2'd2; ds[0] = 1'b0; dc[0] = 1'b0;
    da[1] = 64'hFFFF_0001_FFFF_0001; db[1] = 64'h0001_0001_0001_0001; dm[1] = 2'd0; ds[1] = 1'b0; dc[1] = 1'b0;
    da[2] = 64'h0000_0005_0000_0003; db[2] = 64'h0000_0003_0000_0005; dm[2] = 2'd1; ds[2] = 1'b1; dc[2] = 1'b1;
    for (int i = 3; i < 6; i++) begin
      da[i] = 64'h8000_8000_8000_8000; db[i] = 64'h8000_8000_8000_8000;
      dm[i] = 2'(i - 3); ds[i] = 1'b0; dc[i] = 1'b0;
    end
    es[0] = 64'h0;                   ec[0] = 4'b1000;
    es[1] = 64'h0000_0002_0000_0002; ec[1] = 4'b1010;
    es[2] = 64'h0000_0002_FFFF_FFFE; ec[2] = 4'b1000;
    es[3] = 64'h0;                   ec[3] = 4'b1111;
    es[4] = 64'h0001_0000_0001_0000; ec[4] = 4'b1010;
    es[5] = 64'h0001_0001_0001_0000; ec[5] = 4'b1000;
    for (int t = 0; t < 40 && got < 6; t++) begin
      if (sent < 6) step(1'b0, 1'b1, da[sent], db[sent], dc[sent], dm[sent], ds[sent], 1'b1);
      else step(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 2'd0, 1'b0, 1'b1);
      if (sent < 6 && o_in_ready) sent++;
      if (fire_out) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++; $display("FAIL directed_spurious: S=%h with nothing outstanding", o_s);
        end else begin
          e = q.pop_front();
          if (o_s !== es[got] || o_co !== ec[got] || o_cyc - e.cyc != 4) begin
            miscompares++;
            $display("FAIL directed_case%0d: S=%h Co=%b lat=%0d, want S=%h Co=%b lat=4",
                     got, o_s, o_co, o_cyc - e.cyc, es[got], ec[got]);
          end
          got++;
        end
      end
    end
    vectors++;
    if (got != 6) begin miscompares++; $display("FAIL directed_count: got %0d want 6", got); end
  endtask

  task automatic test_random_stream();
    int   sent = 0;
    int   got = 0;
    logic v;
    ent_t e;
    for (int t = 0; t < 200 && got < 40; t++) begin
      v = (sent < 40) && ($urandom_range(0, 3) != 0);
      step(1'b0, v, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom),
           2'($urandom_range(0, 3)), 1'($urandom), 1'b1);
      if (v && o_in_ready) sent++;
      if (fire_out) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++; $display("FAIL random_spurious: S=%h with nothing outstanding", o_s);
        end else begin
          e = q.pop_front();
          if (o_s !== e.r.s || o_co !== e.r.co || o_cyc - e.cyc != 4) begin
            miscompares++;
            $display("FAIL random_result: S=%h Co=%b lat=%0d, want S=%h Co=%b lat=4",
                     o_s, o_co, o_cyc - e.cyc, e.r.s, e.r.co);
          end
          got++;
        end
      end
    end
    vectors++;
    if (got != 40) begin miscompares++; $display("FAIL random_count: got %0d want 40", got); end
  endtask

  task automatic test_stall();
    int          sent = 0;
    int          got = 0;
    logic        ordy;
    logic        prev_stall = 1'b0;
    logic [63:0] ps = 64'd0;
    logic [3:0]  pc = 4'd0;
    ent_t        e;
    for (int t = 0; t < 60 && got < 8; t++) begin
      ordy = !(t >= 5 && t < 8);
      step(1'b0, sent < 8, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom),
           2'($urandom_range(0, 3)), 1'($urandom), ordy);
      if (sent < 8 && o_in_ready) sent++;
      if (prev_stall) begin
        vectors++;
        if (o_valid !== 1'b1 || o_s !== ps || o_co !== pc) begin
          miscompares++;
          $display("FAIL stall_hold: valid=%b S=%h Co=%b, want valid=1 S=%h Co=%b", o_valid, o_s, o_co, ps, pc);
        end
      end
      if (o_valid && !ordy) begin
        vectors++;
        if (o_in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready: got %b want 0", o_in_ready); end
      end
      prev_stall = o_valid && !ordy;
      ps = o_s;
      pc = o_co;
      if (fire_out) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++; $display("FAIL stall_spurious: S=%h with nothing outstanding", o_s);
        end else begin
          e = q.pop_front();
          if (o_s !== e.r.s || o_co !== e.r.co) begin
            miscompares++;
            $display("FAIL stall_result: S=%h Co=%b, want S=%h Co=%b", o_s, o_co, e.r.s, e.r.co);
          end
          got++;
        end
      end
    end
    vectors++;
    if (got != 8 || q.size() != 0) begin
      miscompares++; $display("FAIL stall_count: got %0d want 8, leftover %0d", got, q.size());
    end
  endtask

  task automatic test_reset_flush();
    int   got = 0;
    ent_t e;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 2'd0, 1'b0, 1'b1);
    end
    step(1'b1, 1'b0, 64'd0, 64'd0, 1'b0, 2'd0, 1'b0, 1'b1);
    q.delete();
    for (int t = 0; t < 10; t++) begin
      step(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 2'd0, 1'b0, 1'b1);
      vectors++;
      if (o_valid !== 1'b0) begin miscompares++; $display("FAIL flush_out_valid: got %b want 0 (S=%h)", o_valid, o_s); end
    end
    step(1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 2'd1, 1'b0, 1'b1);
    for (int t = 0; t < 20 && got < 1; t++) begin
      step(1'b0, 1'b0, 64'd0, 64'd0, 1'b0, 2'd0, 1'b0, 1'b1);
      if (fire_out) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++; $display("FAIL flush_spurious: S=%h with nothing outstanding", o_s);
        end else begin
          e = q.pop_front();
          if (o_s !== e.r.s || o_co !== e.r.co) begin
            miscompares++;
            $display("FAIL flush_after: S=%h Co=%b, want S=%h Co=%b", o_s, o_co, e.r.s, e.r.co);
          end
          got++;
        end
      end
    end
    vectors++;
    if (got != 1) begin miscompares++; $display("FAIL flush_count: got %0d want 1", got); end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.A = 64'd0;
    bus.B = 64'd0;
    bus.Ci = 1'b0;
    bus.mode = 2'd0;
    bus.sub = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_directed();
    test_random_stream();
    test_stall();
    test_reset_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
